s32x_sdram_bridge: RTL and testbench

//  Sits between the 32X SH2 SDRAM port (SDR_A/DO/CS/WE/RD/WAIT) and the board SDRAM controller.

---
 rtl/s32x_sdram_bridge.sv | 186 ++++++++++++++++++
 tb/tb_s32x_sdram_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s32x_sdram_bridge.sv
// s32x_sdram_bridge: SH2 SDRAM port to burst controller bridge.
// Ports: CLK/RST_N, SH2 side (CE_R, SDR_*), controller side (MEM_*).
//   SH2 holds SDR_CS until an access completes; SDR_WAIT stretches it.
//   MEM_REQ is held until MEM_ACK; read fills return LINE_WORDS words.
//   One line buffer gives zero-wait read hits for sequential fetch.
module s32x_sdram_bridge #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 17
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic [ADDR_W-1:0] SDR_A,
  input  logic [15:0]       SDR_DO,
  input  logic              SDR_CS,
  input  logic [1:0]        SDR_WE,
  input  logic              SDR_RD,
  output logic [15:0]       SDR_DI,
  output logic              SDR_WAIT,
  output logic              MEM_REQ,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [1:0]        MEM_BE,
  output logic [15:0]       MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic              MEM_RVALID,
  input  logic [15:0]       MEM_RDATA
);

  localparam int IW = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RFILL,
    S_WRITE,
    S_DONE,
    S_DONE_PEND,
    S_RFILL_TAIL
  } state_e;

  state_e state_q, state_d;

  logic                 line_vld_q;
  logic [ADDR_W-1:IW]   tag_q;
  logic [IW-1:0]        cnt_q;
  logic [IW-1:0]        ridx_q;
  logic                 fill_q;
  logic [15:0]          line_q [LINE_WORDS];
  logic                 mem_req_q;
  logic                 mem_wr_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [1:0]           mem_be_q;
  logic [15:0]          mem_wdata_q;
  logic [15:0]          di_q;

  logic is_wr, hit, ready, done;
  logic rv, rv_last, rv_req, ack;
  logic start_rd, start_wr, wr_merge;

  assign is_wr   = |SDR_WE;
  assign hit     = line_vld_q & ~is_wr &
                   (SDR_A[ADDR_W-1:IW] == tag_q);
  // Returned words only count while a fill is open, so
  // strays after a reset cannot corrupt the line.
  assign rv      = MEM_RVALID & fill_q;
  assign rv_last = rv & (cnt_q == IW'(LINE_WORDS - 1));
  assign rv_req  = rv & (cnt_q == ridx_q);
  assign ack     = MEM_ACK & mem_req_q;
  assign done    = CE_R & SDR_CS & ready;

  assign wr_merge = (state_q == S_WRITE) & ack & line_vld_q &
                    (mem_addr_q[ADDR_W-1:IW] == tag_q);

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    start_rd = 1'b0;
    start_wr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = hit;
        if (SDR_CS & is_wr) begin
          start_wr = 1'b1;
          state_d  = S_WRITE;
        end else if (SDR_CS & SDR_RD & ~hit) begin
          start_rd = 1'b1;
          state_d  = S_RFILL;
        end
      end
      S_RFILL: begin
        // Dropped CS: finish the fill but present nothing.
        if (rv_req) begin
          if (!SDR_CS)
            state_d = rv_last ? S_IDLE : S_RFILL_TAIL;
          else
            state_d = rv_last ? S_DONE : S_DONE_PEND;
        end
      end
      S_WRITE: begin
        if (ack) state_d = SDR_CS ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        ready = 1'b1;
        if (done | ~SDR_CS) state_d = S_IDLE;
      end
      S_DONE_PEND: begin
        ready = 1'b1;
        if (done | ~SDR_CS) state_d = S_RFILL_TAIL;
      end
      S_RFILL_TAIL: begin
        if (!fill_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      line_vld_q  <= 1'b0;
      tag_q       <= '0;
      cnt_q       <= '0;
      ridx_q      <= '0;
      fill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      di_q        <= '0;
    end else begin
      if (ack) mem_req_q <= 1'b0;
      if (start_rd) begin
        mem_req_q  <= 1'b1;
        mem_wr_q   <= 1'b0;
        mem_addr_q <= {SDR_A[ADDR_W-1:IW], {IW{1'b0}}};
        mem_be_q   <= '0;
        ridx_q     <= SDR_A[IW-1:0];
        line_vld_q <= 1'b0;
        fill_q     <= 1'b1;
        cnt_q      <= '0;
      end
      if (start_wr) begin
        mem_req_q   <= 1'b1;
        mem_wr_q    <= 1'b1;
        mem_addr_q  <= SDR_A;
        mem_be_q    <= SDR_WE;
        mem_wdata_q <= SDR_DO;
      end
      if (rv) begin
        cnt_q <= cnt_q + IW'(1);
        if (rv_last) begin
          cnt_q      <= '0;
          fill_q     <= 1'b0;
          line_vld_q <= 1'b1;
          tag_q      <= mem_addr_q[ADDR_W-1:IW];
        end
      end
      if ((state_q == S_RFILL) & rv_req) di_q <= MEM_RDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N & rv) line_q[cnt_q] <= MEM_RDATA;
    if (RST_N & wr_merge) begin
      if (mem_be_q[0])
        line_q[mem_addr_q[IW-1:0]][7:0] <= mem_wdata_q[7:0];
      if (mem_be_q[1])
        line_q[mem_addr_q[IW-1:0]][15:8] <= mem_wdata_q[15:8];
    end
  end

  assign SDR_WAIT  = SDR_CS & ~ready;
  assign SDR_DI    = ((state_q == S_IDLE) & hit) ?
                     line_q[SDR_A[IW-1:0]] : di_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WR    = mem_wr_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_s32x_sdram_bridge.sv
// tb_s32x_sdram_bridge: SH2 master + SDRAM controller model,
// directed scenarios then random traffic against a line model.
module tb_s32x_sdram_bridge;

  logic        CLK, RST_N, CE_R;
  logic [16:0] SDR_A;
  logic [15:0] SDR_DO;
  logic        SDR_CS;
  logic [1:0]  SDR_WE;
  logic        SDR_RD;
  logic [15:0] SDR_DI;
  logic        SDR_WAIT;
  logic        MEM_REQ, MEM_WR;
  logic [16:0] MEM_ADDR;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_WDATA;
  logic        MEM_ACK, MEM_RVALID;
  logic [15:0] MEM_RDATA;

  s32x_sdram_bridge dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
    .SDR_A(SDR_A), .SDR_DO(SDR_DO), .SDR_CS(SDR_CS),
    .SDR_WE(SDR_WE), .SDR_RD(SDR_RD), .SDR_DI(SDR_DI),
    .SDR_WAIT(SDR_WAIT), .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR),
    .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] sdram   [131072];
  logic [15:0] ref_mem [131072];
  logic [15:0] rq [$];

  int ack_fix  = 0;
  int gap_max  = 0;
  bit gap_rand = 0;
  bit ce_rand  = 0;
  int ack_cnt  = -1;
  int gap_cnt  = 0;

  int          rv_sent = 0;
  int          rv_clk  = 0;
  int          req_cnt = 0;
  bit          req_prev = 0;
  logic        lr_wr;
  logic [16:0] lr_addr;
  logic [1:0]  lr_be;
  logic [15:0] lr_wd;
  int          lr_rv;

  logic [15:0] acc_rd;
  int          acc_waits, acc_rel, acc_reqs;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o,
      input logic [1:0] be, input logic [15:0] d);
    merge = o;
    if (be[0]) merge[7:0]  = d[7:0];
    if (be[1]) merge[15:8] = d[15:8];
  endfunction

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CE_R = 0;
    forever begin
      @(negedge CLK);
      CE_R = ce_rand ? 1'($urandom_range(0, 1)) : ~CE_R;
    end
  end

  // SDRAM controller model: acks after a delay, returns the
  // four words of the line in order with optional gaps.
  initial begin
    MEM_ACK = 0; MEM_RVALID = 0; MEM_RDATA = 0;
    forever begin
      @(negedge CLK);
      rv_clk = rv_sent;
      if (MEM_REQ && !req_prev) begin
        req_cnt++;
        lr_wr = MEM_WR; lr_addr = MEM_ADDR;
        lr_be = MEM_BE; lr_wd = MEM_WDATA;
        lr_rv = rv_clk;
      end
      req_prev = MEM_REQ;
      MEM_ACK = 0;
      MEM_RVALID = 0;
      if (MEM_REQ) begin
        if (ack_cnt < 0)
          ack_cnt = ack_fix >= 0 ? ack_fix
                                 : int'($urandom_range(0, 4));
        if (ack_cnt == 0) begin
          MEM_ACK = 1;
          ack_cnt = -1;
          if (MEM_WR)
            sdram[MEM_ADDR] = merge(sdram[MEM_ADDR], MEM_BE,
                                    MEM_WDATA);
          else
            for (int i = 0; i < 4; i++)
              rq.push_back(sdram[MEM_ADDR + 17'(i)]);
        end else ack_cnt--;
      end else ack_cnt = -1;
      if (rq.size() > 0) begin
        if (gap_cnt <= 0) begin
          MEM_RVALID = 1;
          MEM_RDATA  = rq.pop_front();
          rv_sent++;
          gap_cnt = gap_rand ? int'($urandom_range(0, gap_max))
                             : gap_max;
        end else gap_cnt--;
      end
    end
  end

  task automatic acc(input logic [16:0] a, input logic [1:0] we,
                     input logic [15:0] d);
    int r0;
    bit ok;
    @(negedge CLK);
    SDR_CS = 1; SDR_A = a; SDR_WE = we; SDR_DO = d;
    SDR_RD = (we == 2'b00);
    r0 = req_cnt; ok = 0;
    acc_waits = 0; acc_rel = -1; acc_rd = 0;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (!SDR_WAIT && acc_rel < 0) acc_rel = rv_clk;
      if (CE_R && !SDR_WAIT) begin
        ok = 1;
        acc_rd = SDR_DI;
        break;
      end
      if (SDR_WAIT) acc_waits++;
      @(negedge CLK);
    end
    @(posedge CLK);
    acc_reqs = req_cnt - r0;
    chk("acc_complete", 32'(ok), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      SDR_CS = 0; SDR_WE = 0; SDR_RD = 0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && rq.size() > 0; n++)
      @(negedge CLK);
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 0; SDR_CS = 0; SDR_WE = 0; SDR_RD = 0;
    repeat (3) @(negedge CLK);
    RST_N = 1;
  endtask

  initial begin
    int rb, hi, n;
    bit mv;
    logic [16:2] mtag;
    logic [16:0] a;
    logic [1:0]  we;
    logic [15:0] d;
    bit          h;

    RST_N = 0; SDR_A = 0; SDR_DO = 0; SDR_CS = 0;
    SDR_WE = 0; SDR_RD = 0;
    for (int i = 0; i < 131072; i++) begin
      sdram[i]   = 16'(i * 40503 + 7);
      ref_mem[i] = 16'(i * 40503 + 7);
    end

    repeat (3) @(negedge CLK);
    #1;
    chk("rst_req", 32'(MEM_REQ), 0);
    chk("rst_wr", 32'(MEM_WR), 0);
    chk("rst_addr", 32'(MEM_ADDR), 0);
    chk("rst_be", 32'(MEM_BE), 0);
    chk("rst_wdata", 32'(MEM_WDATA), 0);
    chk("rst_di", 32'(SDR_DI), 0);
    chk("rst_wait", 32'(SDR_WAIT), 0);
    RST_N = 1;

    // T1: miss at index 1
    for (int i = 4; i < 8; i++) begin
      sdram[i]   = 16'h1111 * 16'(i - 3);
      ref_mem[i] = 16'h1111 * 16'(i - 3);
    end
    rb = rv_clk;
    acc(17'h00005, 2'b00, 16'h0);
    chk("t1_reqs", 32'(acc_reqs), 1);
    chk("t1_addr", 32'(lr_addr), 32'h4);
    chk("t1_wr", 32'(lr_wr), 0);
    chk("t1_di", 32'(acc_rd), 32'h2222);
    chk("t1_waited", 32'(acc_waits > 0), 1);
    chk("t1_release", 32'(acc_rel - rb), 2);

    // T2: hits across the line, then next line misses
    idle(6);
    for (int i = 4; i < 8; i++) begin
      acc(17'(i), 2'b00, 16'h0);
      chk("t2_hit_wait", 32'(acc_waits), 0);
      chk("t2_hit_reqs", 32'(acc_reqs), 0);
      chk("t2_hit_data", 32'(acc_rd), 32'(16'h1111 * 16'(i - 3)));
    end
    acc(17'h00008, 2'b00, 16'h0);
    chk("t2_miss_reqs", 32'(acc_reqs), 1);
    chk("t2_miss_addr", 32'(lr_addr), 32'h8);
    chk("t2_miss_data", 32'(acc_rd), 32'(ref_mem[8]));

    // T3: write hit merges into the line
    acc(17'h00006, 2'b00, 16'h0);
    chk("t3_refill", 32'(acc_reqs), 1);
    acc(17'h00006, 2'b01, 16'hABCD);
    ref_mem[6] = merge(ref_mem[6], 2'b01, 16'hABCD);
    chk("t3_wreqs", 32'(acc_reqs), 1);
    chk("t3_wwr", 32'(lr_wr), 1);
    chk("t3_wbe", 32'(lr_be), 1);
    chk("t3_waddr", 32'(lr_addr), 32'h6);
    chk("t3_wdata", 32'(lr_wd), 32'hABCD);
    chk("t3_wwait", 32'(acc_waits > 0), 1);
    acc(17'h00006, 2'b00, 16'h0);
    chk("t3_rd_reqs", 32'(acc_reqs), 0);
    chk("t3_rd_wait", 32'(acc_waits), 0);
    chk("t3_rd_data", 32'(acc_rd), 32'h33CD);

    // T4: back-to-back read during the tail of a fill
    gap_max = 3;
    idle(2);
    rb = rv_clk;
    acc(17'h00020, 2'b00, 16'h0);
    chk("t4_a_data", 32'(acc_rd), 32'(ref_mem[17'h20]));
    chk("t4_a_rel", 32'(acc_rel - rb), 1);
    acc(17'h00010, 2'b00, 16'h0);
    chk("t4_b_reqs", 32'(acc_reqs), 1);
    chk("t4_b_addr", 32'(lr_addr), 32'h10);
    chk("t4_b_after4", 32'(lr_rv - rb), 4);
    chk("t4_b_data", 32'(acc_rd), 32'(ref_mem[17'h10]));
    gap_max = 0;
    idle(20);

    // T5: reset in the middle of a fill
    gap_max = 2;
    rb = rv_clk;
    @(negedge CLK);
    SDR_CS = 1; SDR_A = 17'h4; SDR_WE = 0; SDR_RD = 1;
    for (n = 0; n < 100 && (rv_clk - rb) < 2; n++) begin
      @(negedge CLK);
      #1;
    end
    chk("t5_two_rv", 32'(rv_clk - rb), 2);
    RST_N = 0; SDR_CS = 0; SDR_RD = 0;
    @(negedge CLK);
    #1;
    chk("t5_req", 32'(MEM_REQ), 0);
    chk("t5_wait", 32'(SDR_WAIT), 0);
    RST_N = 1;
    drain();
    gap_max = 0;
    acc(17'h00004, 2'b00, 16'h0);
    chk("t5_reqs", 32'(acc_reqs), 1);
    chk("t5_addr", 32'(lr_addr), 32'h4);
    chk("t5_data", 32'(acc_rd), 32'(ref_mem[4]));
    idle(8);

    // T6: slow write ack, request held stable
    ack_fix = 10;
    fork
      acc(17'h00040, 2'b11, 16'hBEEF);
      begin
        for (n = 0; n < 50 && !MEM_REQ; n++) begin
          @(negedge CLK);
          #2;
        end
        chk("t6_req_seen", 32'(MEM_REQ), 1);
        hi = 0;
        while (MEM_REQ && hi < 60) begin
          chk("t6_addr", 32'(MEM_ADDR), 32'h40);
          chk("t6_be", 32'(MEM_BE), 3);
          chk("t6_wdata", 32'(MEM_WDATA), 32'hBEEF);
          chk("t6_wr", 32'(MEM_WR), 1);
          chk("t6_wait", 32'(SDR_WAIT), 1);
          hi++;
          @(negedge CLK);
          #2;
        end
        chk("t6_held", 32'(hi >= 10), 1);
      end
    join
    ref_mem[17'h40] = 16'hBEEF;
    ack_fix = 0;
    acc(17'h00040, 2'b00, 16'h0);
    chk("t6_noalloc", 32'(acc_reqs), 1);
    chk("t6_rdata", 32'(acc_rd), 32'hBEEF);

    // Address wrap: last line, then line 0 must miss
    acc(17'h1FFFF, 2'b00, 16'h0);
    chk("wrap_addr", 32'(lr_addr), 32'h1FFFC);
    chk("wrap_data", 32'(acc_rd), 32'(ref_mem[17'h1FFFF]));
    acc(17'h00003, 2'b00, 16'h0);
    chk("wrap_miss", 32'(acc_reqs), 1);
    chk("wrap_addr0", 32'(lr_addr), 0);
    chk("wrap_data0", 32'(acc_rd), 32'(ref_mem[3]));

    // Random traffic against a one-line model
    idle(10);
    do_reset();
    drain();
    ce_rand = 1; ack_fix = -1; gap_rand = 1; gap_max = 3;
    mv = 0; mtag = 0;
    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 4) == 0) ? 17'h1FFF0 : 17'h00100;
      a = a + 17'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        we = 2'($urandom_range(1, 3));
        d  = 16'($urandom);
        acc(a, we, d);
        ref_mem[a] = merge(ref_mem[a], we, d);
        chk("r_wreqs", 32'(acc_reqs), 1);
        chk("r_waddr", 32'(lr_addr), 32'(a));
        chk("r_wbe", 32'(lr_be), 32'(we));
        chk("r_wdata", 32'(lr_wd), 32'(d));
      end else begin
        h = mv && (mtag == a[16:2]);
        acc(a, 2'b00, 16'h0);
        chk("r_rdata", 32'(acc_rd), 32'(ref_mem[a]));
        chk("r_rreqs", 32'(acc_reqs), h ? 0 : 1);
        if (!h) begin
          chk("r_raddr", 32'(lr_addr), 32'({a[16:2], 2'b00}));
          mv = 1;
          mtag = a[16:2];
        end
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
